// File: rtl/prbs_rx_checker_pkg.sv
// Shared definitions for the PRBS-15 receive checker: FSM states,
// LFSR geometry, sync-pattern framing and small helper functions.
package prbs_rx_checker_pkg;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int unsigned PRBS_W      = 15;  // x^15 + x^14 + 1
  localparam int unsigned PRBS_TAP_HI = 14;
  localparam int unsigned PRBS_TAP_LO = 13;
  localparam int unsigned PAT_BYTES   = 4;
  localparam int unsigned BYTE_W      = 8;

  // Byte idx of the 32-bit sync pattern; byte 0 is the most significant.
  function automatic logic [BYTE_W-1:0] pattern_byte(input logic [31:0] pat,
                                                     input logic [1:0]  idx);
    logic [BYTE_W-1:0] b;
    b = '0;
    unique case (idx)
      2'd0: b = pat[31:24];
      2'd1: b = pat[23:16];
      2'd2: b = pat[15:8];
      2'd3: b = pat[7:0];
    endcase
    return b;
  endfunction

  // Number of set bits in a byte (0..8).
  function automatic logic [3:0] popcount8(input logic [BYTE_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < BYTE_W; i++) c = c + {3'd0, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/prbs_rx_checker_step.sv
// Combinational 8-bit PRBS-15 step. In seed mode the received bits are
// shifted into the register; in check mode the register free-runs on its
// own prediction and each received bit is compared against it.
module prbs15_byte_step
  import prbs_rx_checker_pkg::*;
(
  input  logic [PRBS_W-1:0] state,
  input  logic [BYTE_W-1:0] data,
  input  logic              check_mode,
  output logic [PRBS_W-1:0] next_state,
  output logic [BYTE_W-1:0] err_mask
);

  // Walk the byte MSB first, one LFSR shift per bit.
  always_comb begin
    logic [PRBS_W-1:0] s;
    logic              b;
    logic              pred;
    s        = state;
    err_mask = '0;
    b        = 1'b0;
    pred     = 1'b0;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      b    = data[BYTE_W-1-i];
      pred = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
      if (check_mode) begin
        err_mask[BYTE_W-1-i] = b ^ pred;
        s = {s[PRBS_W-2:0], pred};
      end else begin
        s = {s[PRBS_W-2:0], b};
      end
    end
    next_state = s;
  end

endmodule

// File: rtl/prbs_rx_checker.sv
// PRBS-15 receive checker: hunts for a repeated 32-bit sync pattern,
// seeds its reference LFSR from the next two bytes, then counts bit
// errors on every following byte until too many bad bytes drop lock.
module prbs_rx_checker
  import prbs_rx_checker_pkg::*;
#(
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned LOSS_BYTES  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [31:0]       exp_pattern,
  input  logic [7:0]        n_repeats,
  input  logic              clear_cnt,
  output logic              pattern_done,
  output logic              locked,
  output logic [ERR_W-1:0]  bit_err_cnt,
  output logic [23:0]       byte_cnt,
  output logic              err_flag,
  output logic              lost_lock
);

  localparam int unsigned RUN_W = (LOSS_BYTES < 2) ? 1 : $clog2(LOSS_BYTES + 1);
  localparam logic [3:0]       THRESH   = 4'(LOSS_THRESH);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOSS_BYTES - 1);

  state_t            state;
  logic [1:0]        idx;
  logic [7:0]        rep;
  logic              seed_cnt;
  logic [PRBS_W-1:0] lfsr;
  logic [RUN_W-1:0]  bad_run;

  logic [PRBS_W-1:0] step_next;
  logic [BYTE_W-1:0] step_mask;
  logic [3:0]        byte_errs;
  logic              hunt_match;
  logic [8:0]        rep_inc;
  logic [8:0]        rep_target;
  logic [ERR_W:0]    err_sum;
  logic [ERR_W-1:0]  err_sat;

  prbs15_byte_step u_step (
    .state      (lfsr),
    .data       (rx_data),
    .check_mode (state == ST_CHECK),
    .next_state (step_next),
    .err_mask   (step_mask)
  );

  // Per-byte derived values: match against pattern, repeat target, error sum.
  always_comb begin
    byte_errs  = popcount8(step_mask);
    hunt_match = (rx_data == pattern_byte(exp_pattern, idx));
    rep_inc    = {1'b0, rep} + 9'd1;
    rep_target = (n_repeats == 8'd0) ? 9'd1 : {1'b0, n_repeats};
    err_sum    = {1'b0, bit_err_cnt} + {{(ERR_W-3){1'b0}}, byte_errs};
    err_sat    = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  // Hunt/seed/check FSM with counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      idx          <= '0;
      rep          <= '0;
      seed_cnt     <= 1'b0;
      lfsr         <= '0;
      bad_run      <= '0;
      pattern_done <= 1'b0;
      locked       <= 1'b0;
      bit_err_cnt  <= '0;
      byte_cnt     <= '0;
      err_flag     <= 1'b0;
      lost_lock    <= 1'b0;
    end else begin
      pattern_done <= 1'b0;
      lost_lock    <= 1'b0;
      if (rx_valid) begin
        unique case (state)
          ST_HUNT: begin
            if (hunt_match) begin
              if (idx == 2'(PAT_BYTES - 1)) begin
                idx <= '0;
                if (rep_inc >= rep_target) begin
                  rep          <= '0;
                  seed_cnt     <= 1'b0;
                  pattern_done <= 1'b1;
                  state        <= ST_SEED;
                end else begin
                  rep <= rep_inc[7:0];
                end
              end else begin
                idx <= idx + 2'd1;
              end
            end else begin
              rep <= '0;
              idx <= (rx_data == pattern_byte(exp_pattern, 2'd0)) ? 2'd1 : 2'd0;
            end
          end
          ST_SEED: begin
            lfsr     <= step_next;
            seed_cnt <= 1'b1;
            if (seed_cnt) begin
              state   <= ST_CHECK;
              locked  <= 1'b1;
              bad_run <= '0;
            end
          end
          ST_CHECK: begin
            lfsr        <= step_next;
            err_flag    <= (byte_errs != 4'd0);
            bit_err_cnt <= err_sat;
            byte_cnt    <= byte_cnt + 24'd1;
            if (byte_errs >= THRESH) begin
              if (bad_run == RUN_LAST) begin
                bad_run   <= '0;
                lost_lock <= 1'b1;
                locked    <= 1'b0;
                idx       <= '0;
                rep       <= '0;
                state     <= ST_HUNT;
              end else begin
                bad_run <= bad_run + RUN_W'(1);
              end
            end else begin
              bad_run <= '0;
            end
          end
          default: state <= ST_HUNT;
        endcase
      end
      // Placed last so a clear overrides the same-cycle count update.
      if (clear_cnt) begin
        bit_err_cnt <= '0;
        byte_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Directed, self-checking bench for prbs_rx_checker with a scoreboard of
// expected per-byte outputs and an independent PRBS-15 reference source.
module tb_prbs_rx_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] exp_pattern;
  logic [7:0]  n_repeats;
  logic        clear_cnt;
  logic        pattern_done;
  logic        locked;
  logic [15:0] bit_err_cnt;
  logic [23:0] byte_cnt;
  logic        err_flag;
  logic        lost_lock;

  prbs_rx_checker #(.ERR_W(16), .LOSS_THRESH(4), .LOSS_BYTES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .exp_pattern  (exp_pattern),
    .n_repeats    (n_repeats),
    .clear_cnt    (clear_cnt),
    .pattern_done (pattern_done),
    .locked       (locked),
    .bit_err_cnt  (bit_err_cnt),
    .byte_cnt     (byte_cnt),
    .err_flag     (err_flag),
    .lost_lock    (lost_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        pd;
    logic        lk;
    logic        ef;
    bit          chk_ef;
    logic        ll;
    logic [15:0] errc;
    logic [23:0] bytec;
  } exp_t;

  exp_t sb[$];

  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  // Expected-state tracking for the scoreboard entries
  logic [15:0] e_err   = '0;
  logic [23:0] e_bytes = '0;
  logic        e_ef    = 1'b0;
  logic        e_lk    = 1'b0;
  logic [14:0] ref_s   = '0;

  logic [31:0] pat = 32'hABCDEF58;
  logic [7:0]  b;
  logic [7:0]  restart_stream [6] = '{8'hAB, 8'hCD, 8'hAB, 8'hCD, 8'hEF, 8'h58};

  task automatic chk(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic pd, input logic ll, input bit chk_ef);
    exp_t e;
    e.tag = tag; e.pd = pd; e.lk = e_lk; e.ef = e_ef; e.chk_ef = chk_ef;
    e.ll = ll; e.errc = e_err; e.bytec = e_bytes;
    sb.push_back(e);
  endtask

  // One clock of stimulus; any queued expectation is compared after the edge.
  task automatic send(input logic [7:0] d, input logic v, input logic clr);
    exp_t e;
    @(negedge clk);
    rx_data = d; rx_valid = v; clear_cnt = clr;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; clear_cnt = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, "pattern_done", 32'(pattern_done), 32'(e.pd));
      chk(e.tag, "locked",       32'(locked),       32'(e.lk));
      chk(e.tag, "lost_lock",    32'(lost_lock),    32'(e.ll));
      chk(e.tag, "bit_err_cnt",  32'(bit_err_cnt),  32'(e.errc));
      chk(e.tag, "byte_cnt",     32'(byte_cnt),     32'(e.bytec));
      if (e.chk_ef) chk(e.tag, "err_flag", 32'(err_flag), 32'(e.ef));
    end
  endtask

  // Next byte of the reference PRBS-15 stream, MSB first.
  task automatic prbs_byte(output logic [7:0] o);
    logic bit_v;
    o = '0;
    for (int i = 7; i >= 0; i--) begin
      bit_v = ref_s[14] ^ ref_s[13];
      o[i]  = bit_v;
      ref_s = {ref_s[13:0], bit_v};
    end
  endtask

  task automatic seed(input string tag, input logic [7:0] s0, input logic [7:0] s1);
    logic [15:0] w;
    push({tag, "_seed0"}, 1'b0, 1'b0, 1'b1);
    send(s0, 1'b1, 1'b0);
    e_lk = 1'b1;
    push({tag, "_seed1"}, 1'b0, 1'b0, 1'b1);
    send(s1, 1'b1, 1'b0);
    w = {s0, s1};
    ref_s = w[14:0];
  endtask

  task automatic lose_lock(input string tag);
    logic [7:0] pb;
    for (int k = 0; k < 3; k++) begin
      prbs_byte(pb);
      e_err   = e_err + 16'd8;
      e_bytes = e_bytes + 24'd1;
      e_ef    = 1'b1;
      if (k == 2) e_lk = 1'b0;
      push(tag, 1'b0, (k == 2), 1'b1);
      send(~pb, 1'b1, 1'b0);
    end
  endtask

  task automatic restart_hunt(input string tag);
    for (int k = 0; k < 6; k++) begin
      push(tag, (k == 5), 1'b0, 1'b1);
      send(restart_stream[k], 1'b1, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; clear_cnt = 1'b0;
    exp_pattern = pat; n_repeats = 8'd3;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "locked",      32'(locked),      32'd0);
    chk("reset", "bit_err_cnt", 32'(bit_err_cnt), 32'd0);
    chk("reset", "byte_cnt",    32'(byte_cnt),    32'd0);
    chk("reset", "pd_ll_ef",    {29'd0, pattern_done, lost_lock, err_flag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pattern x3, pulse after 12th byte, then seed to lock
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) begin
        push("t1_hunt", (r == 2 && k == 3), 1'b0, 1'b1);
        send(pat[31-8*k -: 8], 1'b1, 1'b0);
      end
    push("t1_idle", 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    seed("t1", 8'h12, 8'h34);

    // 2: 100 clean PRBS bytes
    for (int k = 0; k < 100; k++) begin
      prbs_byte(b);
      e_bytes = e_bytes + 24'd1;
      push("t2_clean", 1'b0, 1'b0, 1'b1);
      send(b, 1'b1, 1'b0);
    end
    push("t2_hold", 1'b0, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b0);

    // 3: single flipped bit, then clean byte clears err_flag
    prbs_byte(b);
    e_err = 16'd1; e_bytes = e_bytes + 24'd1; e_ef = 1'b1;
    push("t3_flip", 1'b0, 1'b0, 1'b1);
    send(b ^ 8'h01, 1'b1, 1'b0);
    prbs_byte(b);
    e_bytes = e_bytes + 24'd1; e_ef = 1'b0;
    push("t3_clean", 1'b0, 1'b0, 1'b1);
    send(b, 1'b1, 1'b0);

    // clear while idle
    e_err = '0; e_bytes = '0;
    push("clear_idle", 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b1);

    // 5: three inverted bytes drop lock with 24 bit errors
    lose_lock("t5_bad");
    push("t5_after", 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    push("t5_hunt_nochk", 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b1, 1'b0);

    // 4: restart inside the pattern, n=1 then n=0
    n_repeats = 8'd1;
    restart_hunt("t4_n1");
    seed("t4_n1", 8'h5A, 8'hC3);
    for (int k = 0; k < 2; k++) begin
      prbs_byte(b);
      e_bytes = e_bytes + 24'd1; e_ef = 1'b0;
      push("t4_clean", 1'b0, 1'b0, 1'b1);
      send(b, 1'b1, 1'b0);
    end
    lose_lock("t4_drop");
    n_repeats = 8'd0;
    restart_hunt("t4_n0");
    seed("t4_n0", 8'h21, 8'h87);

    // 6: clear wins over a same-cycle errored byte
    prbs_byte(b);
    e_err = '0; e_bytes = '0;
    push("t6_clr_same", 1'b0, 1'b0, 1'b0);
    send(b ^ 8'hFF, 1'b1, 1'b1);
    // Drive the counter close to all-ones with 3-error bytes (below threshold)
    for (int k = 0; k < 21844; k++) begin
      prbs_byte(b);
      send(b ^ 8'h07, 1'b1, 1'b0);
    end
    e_err = 16'd65532; e_bytes = 24'd21844; e_ef = 1'b1;
    push("t6_near", 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b0);
    prbs_byte(b);
    e_err = 16'hFFFF; e_bytes = e_bytes + 24'd1;
    push("t6_full", 1'b0, 1'b0, 1'b1);
    send(b ^ 8'h07, 1'b1, 1'b0);
    prbs_byte(b);
    e_bytes = e_bytes + 24'd1;
    push("t6_sat", 1'b0, 1'b0, 1'b1);
    send(b ^ 8'h07, 1'b1, 1'b0);
    e_err = '0; e_bytes = '0;
    push("t6_clear", 1'b0, 1'b0, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    prbs_byte(b);
    e_err = 16'd3; e_bytes = 24'd1;
    push("t6_pre_rst", 1'b0, 1'b0, 1'b1);
    send(b ^ 8'h07, 1'b1, 1'b0);

    // Asynchronous reset while locked, checked before any clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", "locked",      32'(locked),      32'd0);
    chk("async_rst", "bit_err_cnt", 32'(bit_err_cnt), 32'd0);
    chk("async_rst", "byte_cnt",    32'(byte_cnt),    32'd0);
    chk("async_rst", "err_flag",    32'(err_flag),    32'd0);
    chk("async_rst", "pd_ll",       {30'd0, pattern_done, lost_lock}, 32'd0);
    chk("sb", "leftover", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
